// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the MIPS multiply/divide unit.
//   - op encodings driven by the core on the unit's `op` port
//   - FSM state enum used by mips_muldiv_unit (also exposed on its debug port)
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational conditional two's-complement negate.
// Used both to take absolute values of signed operands and to restore the
// sign of products, quotients and remainders.
// Ports:
//   i_neg  - negate when 1, pass through when 0
//   i_val  - value in
//   o_val  - i_neg ? -i_val : i_val
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: multi-cycle multiply/divide unit with the HI/LO pair.
// Implements mult, multu, div, divu (iterative, one bit per cycle) plus
// mthi/mtlo writes. Signed ops run on absolute values; the sign is restored
// in the FIX state.
//
// Handshake: the core raises `start` for one cycle while `busy`=0; the edge
// that samples it launches the op. `busy` stays high until the edge that
// writes HI/LO, after which `done` pulses for exactly one cycle (busy and
// done are never high together). `start` seen while busy is ignored; a new
// `start` may be issued in the `done` cycle.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start, op           - launch request and op select (see muldiv_pkg)
//   operand_a/operand_b - rs / rt values
//   hi_wr, lo_wr        - mthi / mtlo (operand_a -> HI / LO), IDLE only
//   busy, done          - status, both registered
//   div_by_zero         - sticky flag for the most recent operation
//   hi, lo              - HI / LO registers
//   dbg_state           - current FSM state (md_state_t encoding)
//
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// div/divu complete in one edge with HI=LO=0 and no flag.
module mips_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_t          r_state, w_state_nxt;
  logic               r_is_div, r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_m;     // multiplicand or divisor (absolute)
  logic [2*WIDTH-1:0] r_acc;   // {upper, lower}: product, or {remainder, quotient}
  logic [CW-1:0]      r_cnt;
  logic               r_busy, r_done, r_dbz;
  logic [WIDTH-1:0]   r_hi, r_lo;

  // Launch decode
  logic               w_is_div, w_signed, w_neg_a, w_neg_b;
  logic               w_fast;       // op skips CALC and finishes in one edge
  logic               w_fast_dbz;
  logic [2*WIDTH-1:0] w_fast_acc;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;

  assign w_is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign w_signed = (op == MD_MULT) || (op == MD_DIV);
  assign w_neg_a  = w_signed && operand_a[WIDTH-1];
  assign w_neg_b  = w_signed && operand_b[WIDTH-1];

`ifdef MULDIV_DIV_EN
  // Divide by zero: HI keeps the raw dividend, LO is all ones.
  assign w_fast     = w_is_div && (operand_b == '0);
  assign w_fast_dbz = 1'b1;
  assign w_fast_acc = {operand_a, {WIDTH{1'b1}}};
`else
  assign w_fast     = w_is_div;
  assign w_fast_dbz = 1'b0;
  assign w_fast_acc = '0;
`endif

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.i_neg(w_neg_a), .i_val(operand_a), .o_val(w_abs_a));
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.i_neg(w_neg_b), .i_val(operand_b), .o_val(w_abs_b));

  // One iteration step. Multiply: conditional add into the upper half, then
  // shift right (carry enters at the top).
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step, w_step;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
  assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  // Restoring divide: shift the next dividend bit into the remainder, keep
  // the difference if it did not go negative, and shift in the quotient bit.
  logic [WIDTH:0]     w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_div_step;

  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_m};
  assign w_div_step = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
  assign w_step     = r_is_div ? w_div_step : w_mul_step;
`else
  assign w_step     = w_mul_step;
`endif

  // Result sign correction
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix, w_res_hi, w_res_lo;

  muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.i_neg(r_neg_q), .i_val(r_acc),                    .o_val(w_prod_fix));
  muldiv_sign_fix #(.WIDTH(WIDTH))   u_fix_quo  (.i_neg(r_neg_q), .i_val(r_acc[WIDTH-1:0]),         .o_val(w_quo_fix));
  muldiv_sign_fix #(.WIDTH(WIDTH))   u_fix_rem  (.i_neg(r_neg_r), .i_val(r_acc[2*WIDTH-1:WIDTH]),   .o_val(w_rem_fix));

  assign w_res_hi = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (start) w_state_nxt = w_fast ? MD_FIX : MD_CALC;
      MD_CALC: if (r_cnt == CNT_LAST) w_state_nxt = MD_FIX;
      MD_FIX:  w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= MD_IDLE;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_m      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != MD_IDLE);
      r_done  <= (r_state == MD_FIX);
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            r_is_div <= w_is_div;
            r_m      <= w_abs_b;
            r_cnt    <= '0;
            if (w_fast) begin
              r_acc   <= w_fast_acc;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_dbz   <= w_fast_dbz;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_neg_q <= w_neg_a ^ w_neg_b;
              r_neg_r <= w_neg_a;   // remainder follows the dividend
              r_dbz   <= 1'b0;
            end
          end else begin
            if (hi_wr) r_hi <= operand_a;
            if (lo_wr) r_lo <= operand_a;
          end
        end
        MD_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CW'(1);
        end
        MD_FIX: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed bench for mips_muldiv_unit (WIDTH=32).
// Divide expectations follow the MULDIV_DIV_EN build option.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];   // expected {hi, lo} per launched operation

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_wr(hi_wr), .lo_wr(lo_wr),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    step();
    start = 1'b0;
  endtask

  // Called just after the accepting edge; returns edges until done is seen
  // and the number of sampled busy cycles. Bounded at 100 edges.
  task automatic wait_done(output int lat, output int busy_cnt, output int overlap);
    lat = 0; busy_cnt = 0; overlap = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res,
                        input logic exp_dbz, input int exp_lat);
    int lat, bc, ov;
    logic [63:0] e;
    exp_q.push_back(exp_res);
    launch(o, a, b);
    wait_done(lat, bc, ov);
    e = exp_q.pop_front();
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hilo"}, {hi, lo}, e);
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
  endtask

  initial begin
    int lat, bc, ov, n_done;
    logic [63:0] e;

    // Reset state
    repeat (2) step();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_state", 64'(dbg_state), 64'(0));
    reset = 1'b0;
    step();

    // multu max x max: latency, busy width, one-cycle done
    exp_q.push_back(64'hFFFFFFFE_00000001);
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc, ov);
    e = exp_q.pop_front();
    check("multu_max_lat", 64'(lat), 64'(33));
    check("multu_max_busy", 64'(bc), 64'(33));
    check("multu_max_overlap", 64'(ov), 64'(0));
    check("multu_max_hilo", {hi, lo}, e);
    check("multu_max_busy_at_done", 64'(busy), 64'(0));
    step();
    check("multu_max_done_pulse", 64'(done), 64'(0));

    // Signed multiply
    run_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 33);

`ifdef MULDIV_DIV_EN
    run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33);
    run_op("divu_5d0", 2'b11, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, 1);
    run_op("multu_2x3", 2'b01, 32'd2, 32'd3, 64'h00000000_00000006, 1'b0, 33);
    run_op("div_minm1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33);
`else
    run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 64'h0, 1'b0, 1);
    run_op("divu_5d0", 2'b11, 32'd5, 32'd0, 64'h0, 1'b0, 1);
    run_op("multu_2x3", 2'b01, 32'd2, 32'd3, 64'h00000000_00000006, 1'b0, 33);
    run_op("div_minm1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h0, 1'b0, 1);
`endif
    // Back-to-back: launched in the done cycle of the previous op
    run_op("mult_m1xm1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0, 33);
    run_op("mult_minxmin", 2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 33);

    // start + lo_wr while busy are ignored
    exp_q.push_back(64'h00000000_00300000);
    launch(2'b01, 32'h00010000, 32'h00000030);
    repeat (4) step();
    start = 1'b1; op = 2'b01; operand_a = 32'd7; operand_b = 32'd7; lo_wr = 1'b1;
    step();
    start = 1'b0; lo_wr = 1'b0;
    check("ignore_busy", 64'(busy), 64'(1));
    wait_done(lat, bc, ov);
    e = exp_q.pop_front();
    check("ignore_lat", 64'(lat), 64'(28));
    check("ignore_hilo", {hi, lo}, e);
    step();

    // mtlo / mthi in IDLE
    operand_a = 32'h00001234; lo_wr = 1'b1;
    step();
    lo_wr = 1'b0;
    check("mtlo_hilo", {hi, lo}, 64'h00000000_00001234);
    operand_a = 32'h0000ABCD; hi_wr = 1'b1;
    step();
    hi_wr = 1'b0;
    check("mthi_hilo", {hi, lo}, 64'h0000ABCD_00001234);

    // hi_wr alongside start: start wins, HI untouched during the op
    hi_wr = 1'b1;
    exp_q.push_back(64'h00000000_00000004);
    launch(2'b01, 32'd2, 32'd2);
    hi_wr = 1'b0;
    check("start_wins_hi", 64'(hi), 64'h0000ABCD);
    wait_done(lat, bc, ov);
    e = exp_q.pop_front();
    check("start_wins_hilo", {hi, lo}, e);
    step();

    // Reset mid-CALC
    launch(2'b01, 32'h00001234, 32'h00005678);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy_done", {62'h0, busy, done}, 64'h0);
    check("midrst_hilo", {hi, lo}, 64'h0);
    check("midrst_dbz", 64'(div_by_zero), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(0));
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) n_done++;
      step();
    end
    check("midrst_no_done", 64'(n_done), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
